pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register used between any two stages of the MIPS pipeline, such as issue→execute, execute→memory, and memory→writeback. It carries a packed control field and a packed data field, and supports the following:
- a valid/ready handshake, so stages can stall;
- a flush input that squashes the held instruction;
- an optional two-entry skid buffer, which gives a registered ready at full throughput;
- a saturating stall counter for performance analysis.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/pipe_sat_cnt.sv | 13 +
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register state encoding, per-stage widths and control field layouts
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam int EX_CTRL_W  = 16;
  localparam int EX_DATA_W  = 128;
  localparam int MEM_CTRL_W = 8;
  localparam int MEM_DATA_W = 96;
  localparam int WB_CTRL_W  = 4;
  localparam int WB_DATA_W  = 64;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       reg_wr;
    logic [3:0] rsvd;
  } ex_ctrl_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] size;
    logic       sign_ext;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       rsvd;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_to_reg;
    logic [1:0] rsvd;
  } wb_ctrl_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with synchronous clear
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // count up on inc, sticking at all-ones instead of wrapping
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with flush, stall counter and optional skid entry (PIPE_STAGE_REG_SKID_EN)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 16,
  parameter int DATA_W   = 128,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  state_t state, state_nx;
  logic up, dn, stall;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  assign valid_o = state != ST_EMPTY;
  assign up      = valid_i && ready_o;
  assign dn      = valid_o && ready_i;
  assign stall   = valid_o && !ready_i;
  assign data_o  = data_q;

  // state register; flush and reset both drop every held entry
  always_ff @(posedge clk)
    state <= reset || clr ? ST_EMPTY : state_nx;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              ready_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // next state: an arrival during a stall spills into the skid entry
  always_comb
    state_nx = state == ST_SKID ? (dn ? ST_FULL : ST_SKID) :
               up ? (stall ? ST_SKID : ST_FULL) :
               dn ? ST_EMPTY : state;

  // ready is a flop so nothing combinational links ready_i to ready_o
  always_ff @(posedge clk)
    ready_q <= reset || clr || state_nx != ST_SKID;

  // skid entry captures the arrival the stalled main entry cannot take
  always_ff @(posedge clk)
    if (reset) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (up && stall && !clr) begin
      skid_ctrl <= ctrl_i;
      skid_data <= data_i;
    end

  assign ready_o = ready_q;
`else
  // next state: single entry fills on arrival and empties on departure
  always_comb
    state_nx = up ? ST_FULL : dn ? ST_EMPTY : state;

  assign ready_o = !valid_o || ready_i;
`endif

  // main entry; when a skid entry exists it refills main first to keep arrival order
  always_ff @(posedge clk)
    if (reset) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (clr) begin
      ctrl_q <= '0;
      if (CLR_DATA != 0) data_q <= '0;
    end
`ifdef PIPE_STAGE_REG_SKID_EN
    else if (state == ST_SKID) begin
      if (dn) begin
        ctrl_q <= skid_ctrl;
        data_q <= skid_data;
      end
    end else if (up && !stall) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
`else
    else if (up) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
`endif

  // bubbles present an all-zero control field so no write strobe leaks downstream
  always_comb
    ctrl_o = valid_o ? ctrl_q : '0;

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk),
    .clr(reset),
    .inc(stall),
    .cnt(stall_cnt_o)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int CMAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 0, reset = 1, clr = 0, valid_i = 0, ready_i = 1;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;
  logic ready_o, valid_o;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [NW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .clr(clr), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
    .ctrl_o(ctrl_o), .data_o(data_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  logic [DW-1:0] hold = '0;
  int cnt = 0;
  bit live = 0;
  int checks = 0, errors = 0;

  function automatic bit m_ready();
    return CAP == 2 ? q.size() < 2 : (q.size() == 0 || ready_i);
  endfunction

  function automatic logic [CW-1:0] m_ctrl();
    return q.size() > 0 ? q[0].c : '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : model
    bit up, dn;
    up = valid_i && m_ready();
    dn = q.size() > 0 && ready_i;
    if (reset) begin
      q.delete();
      hold = '0;
      cnt = 0;
      live = 1;
    end else begin
      if (q.size() > 0 && !ready_i && cnt < CMAX) cnt++;
      if (clr) begin
        q.delete();
        hold = '0;
      end else begin
        if (dn) void'(q.pop_front());
        if (up) q.push_back(ent_t'{ctrl_i, data_i});
        if (q.size() > 0) hold = q[0].d;
      end
    end
  end

  always @(negedge clk) if (live) begin
    chk("valid_o", valid_o, q.size() > 0);
    chk("ready_o", ready_o, m_ready());
    chk("ctrl_o", ctrl_o, m_ctrl());
    chk("data_o", data_o, hold);
    chk("stall_cnt_o", stall_cnt_o, cnt);
  end

  initial begin
    step();
    step();
    chk("rst valid_o", valid_o, 0);
    chk("rst ctrl_o", ctrl_o, 0);
    chk("rst data_o", data_o, 0);
    chk("rst stall", stall_cnt_o, 0);
    chk("rst ready_o", ready_o, 1);
    reset = 0;
    for (int k = 1; k <= 4; k++) begin
      valid_i = 1;
      ready_i = 1;
      ctrl_i = CW'(k);
      data_i = 32'hA000 + k;
      step();
      chk("stream valid_o", valid_o, 1);
      chk("stream ctrl_o", ctrl_o, k);
    end
    chk("stream stall", stall_cnt_o, 0);
    valid_i = 0;
    ready_i = 0;
    repeat (5) step();
    chk("stall cnt5", stall_cnt_o, 5);
    chk("stall ctrl_o", ctrl_o, 4);
    chk("stall data_o", data_o, 32'hA004);
`ifndef PIPE_STAGE_REG_SKID_EN
    chk("stall ready_o", ready_o, 0);
`endif
    repeat (15) step();
    chk("sat cnt", stall_cnt_o, 15);
    repeat (5) step();
    chk("sat nowrap", stall_cnt_o, 15);
    valid_i = 1;
    ctrl_i = 16'hBEEF;
    data_i = 32'hDEADBEEF;
    clr = 1;
    step();
    clr = 0;
    valid_i = 0;
    chk("flush valid_o", valid_o, 0);
    chk("flush ctrl_o", ctrl_o, 0);
    chk("flush data_o", data_o, 0);
    chk("flush keeps cnt", stall_cnt_o, 15);
    ready_i = 1;
    step();
    chk("squashed never appears", valid_o, 0);
    reset = 1;
    step();
    reset = 0;
    chk("reset clears cnt", stall_cnt_o, 0);
    ctrl_i = 16'hFFFF;
    repeat (3) step();
    chk("bubble valid_o", valid_o, 0);
    chk("bubble ctrl_o", ctrl_o, 0);
    ready_i = 0;
    valid_i = 1;
    ctrl_i = 16'h0005;
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    valid_i = 0;
    chk("midstall rst valid_o", valid_o, 0);
    chk("midstall rst ctrl_o", ctrl_o, 0);
    chk("midstall rst ready_o", ready_o, 1);
    repeat (3000) begin
      valid_i = $urandom_range(0, 9) < 7;
      ready_i = $urandom_range(0, 9) < 6;
      clr = $urandom_range(0, 99) < 3;
      reset = $urandom_range(0, 199) < 1;
      ctrl_i = CW'($urandom);
      data_i = $urandom;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
